// File: rtl/dma_bus_arbiter_if.sv
// Bus handshake between the CPU MEM stage, the DMA engine and the arbiter.
// The arbiter uses the slave view; the requesters (or a bench) use master.
interface dma_bus_arbiter_if #(
    parameter int CNT_W = 3
);
    logic             cpu_mem_req;
    logic             cpu_mem_done;
    logic             dma_br;
    logic             dma_word_done;
    logic             bg;
    logic             cpu_bus_en;
    logic             stall_pipe;
    logic             dma_cmpl;
    logic             dma_abort;
    logic [CNT_W-1:0] word_cnt;

    modport slave (
        input  cpu_mem_req,
        input  cpu_mem_done,
        input  dma_br,
        input  dma_word_done,
        output bg,
        output cpu_bus_en,
        output stall_pipe,
        output dma_cmpl,
        output dma_abort,
        output word_cnt
    );

    modport master (
        output cpu_mem_req,
        output cpu_mem_done,
        output dma_br,
        output dma_word_done,
        input  bg,
        input  cpu_bus_en,
        input  stall_pipe,
        input  dma_cmpl,
        input  dma_abort,
        input  word_cnt
    );
endinterface

// File: rtl/dma_bus_arbiter.sv
// Memory-bus arbiter between the CPU MEM stage and the DMA engine.
// A DMA request waits for any in-flight CPU access, then owns the bus for
// at most BURST_LEN words, then spends one RELEASE cycle handing it back.
module dma_bus_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    dma_bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        GRANT,
        RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_LEN - 1);

    state_t           r_state;
    logic             r_bg;
    logic             r_cpu_bus_en;
    logic             r_dma_cmpl;
    logic             r_dma_abort;
    logic [CNT_W-1:0] r_word_cnt;

    // Arbitration FSM with registered bus-ownership outputs and word counter.
    // NOTE: reset is tested inside the clocked block, so it is synchronous and
    // stays out of the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge register values regardless of statement order.
            r_state      <= IDLE;
            r_word_cnt   <= '0;
            r_bg         <= 1'b0;
            r_cpu_bus_en <= 1'b1;
            r_dma_cmpl   <= 1'b0;
            r_dma_abort  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.dma_br) begin
                        // A pending CPU access always wins over a new DMA request.
                        if (bus.cpu_mem_req && !bus.cpu_mem_done) begin
                            r_state <= DRAIN;
                        end else begin
                            r_state      <= GRANT;
                            r_bg         <= 1'b1;
                            r_cpu_bus_en <= 1'b0;
                        end
                    end
                end

                DRAIN: begin
                    // A withdrawn request is honoured before the CPU completion.
                    if (!bus.dma_br) begin
                        r_state <= IDLE;
                    end else if (bus.cpu_mem_done) begin
                        r_state      <= GRANT;
                        r_bg         <= 1'b1;
                        r_cpu_bus_en <= 1'b0;
                    end
                end

                GRANT: begin
                    // A dropped request aborts; a word in the same cycle is not counted.
                    if (!bus.dma_br) begin
                        r_state      <= RELEASE;
                        r_bg         <= 1'b0;
                        r_cpu_bus_en <= 1'b1;
                        r_dma_abort  <= 1'b1;
                    end else if (bus.dma_word_done) begin
                        r_word_cnt <= r_word_cnt + CNT_W'(1);
                        if (r_word_cnt == LAST_WORD) begin
                            r_state      <= RELEASE;
                            r_bg         <= 1'b0;
                            r_cpu_bus_en <= 1'b1;
                            r_dma_cmpl   <= 1'b1;
                        end
                    end
                end

                RELEASE: begin
                    // Unconditional return to IDLE gives the CPU at least one cycle.
                    r_state     <= IDLE;
                    r_word_cnt  <= '0;
                    r_dma_cmpl  <= 1'b0;
                    r_dma_abort <= 1'b0;
                end

                default: begin
                    r_state      <= IDLE;
                    r_word_cnt   <= '0;
                    r_bg         <= 1'b0;
                    r_cpu_bus_en <= 1'b1;
                    r_dma_cmpl   <= 1'b0;
                    r_dma_abort  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bg         = r_bg;
    assign bus.cpu_bus_en = r_cpu_bus_en;
    assign bus.dma_cmpl   = r_dma_cmpl;
    assign bus.dma_abort  = r_dma_abort;
    assign bus.word_cnt   = r_word_cnt;

    // Stall is combinational so a CPU access that arrives mid-grant freezes
    // the pipeline in that very cycle and releases it in the RELEASE cycle.
    assign bus.stall_pipe = (r_state == GRANT) && bus.cpu_mem_req;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Scoreboard bench for dma_bus_arbiter: the driver applies one directed
// vector per cycle and queues the hand-computed outputs for that cycle; the
// monitor pops and compares on every falling edge while entries are queued.
module tb_dma_bus_arbiter;

    localparam int BURST_LEN = 4;
    localparam int CNT_W     = 3;

    logic clk;
    logic reset_n;

    dma_bus_arbiter_if #(.CNT_W(CNT_W)) bus ();

    dma_bus_arbiter #(
        .BURST_LEN (BURST_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Expected output word: {bg, cpu_bus_en, stall_pipe, dma_cmpl, dma_abort, word_cnt}
    typedef struct {
        string      name;
        logic [7:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_vectors;
    int   n_miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare the DUT outputs against the oldest queued expectation.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {bus.bg, bus.cpu_bus_en, bus.stall_pipe,
                       bus.dma_cmpl, bus.dma_abort, bus.word_cnt};
                n_vectors++;
                if (act !== e.exp) begin
                    n_miscompares++;
                    $display("FAIL %s: got bg/en/stall/cmpl/abort=%b cnt=%0d, want bg/en/stall/cmpl/abort=%b cnt=%0d",
                             e.name, act[7:3], act[2:0], e.exp[7:3], e.exp[2:0]);
                end
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected in that cycle.
    task automatic v(input string name,
                     input logic rn, input logic req, input logic done,
                     input logic br, input logic wd,
                     input logic bg, input logic en, input logic st,
                     input logic cm, input logic ab, input int cnt);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n           = rn;
        bus.cpu_mem_req   = req;
        bus.cpu_mem_done  = done;
        bus.dma_br        = br;
        bus.dma_word_done = wd;
        e.name = name;
        e.exp  = {bg, en, st, cm, ab, 3'(cnt)};
        exp_q.push_back(e);
    endtask

    initial begin
        n_vectors         = 0;
        n_miscompares     = 0;
        reset_n           = 1'b0;
        bus.cpu_mem_req   = 1'b0;
        bus.cpu_mem_done  = 1'b0;
        bus.dma_br        = 1'b0;
        bus.dma_word_done = 1'b0;
        repeat (2) @(posedge clk);

        //       name             rn req dn br wd   bg en st cm ab cnt
        // Reset state, then a clean full burst with the CPU idle.
        v("reset_idle",      1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);
        v("br_seen",         1, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0);
        v("burst_w0",        1, 0, 0, 1, 1,   1, 0, 0, 0, 0, 0);
        v("burst_w1",        1, 0, 0, 1, 1,   1, 0, 0, 0, 0, 1);
        v("burst_w2",        1, 0, 0, 1, 1,   1, 0, 0, 0, 0, 2);
        v("burst_w3",        1, 0, 0, 1, 1,   1, 0, 0, 0, 0, 3);
        v("burst_release",   1, 0, 0, 0, 0,   0, 1, 0, 1, 0, 4);
        v("burst_idle",      1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);

        // CPU access in flight when the DMA asks: drain, then grant.
        v("drain_enter",     1, 1, 0, 1, 0,   0, 1, 0, 0, 0, 0);
        v("drain_c1",        1, 1, 0, 1, 0,   0, 1, 0, 0, 0, 0);
        v("drain_c2",        1, 1, 0, 1, 0,   0, 1, 0, 0, 0, 0);
        v("drain_done",      1, 1, 1, 1, 0,   0, 1, 0, 0, 0, 0);
        v("drain_grant",     1, 0, 0, 1, 0,   1, 0, 0, 0, 0, 0);

        // CPU request during grant stalls; drop with a word aborts at cnt 2.
        v("stall_w0",        1, 1, 0, 1, 1,   1, 0, 1, 0, 0, 0);
        v("stall_nowd",      1, 1, 0, 1, 0,   1, 0, 1, 0, 0, 1);
        v("stall_w1",        1, 1, 0, 1, 1,   1, 0, 1, 0, 0, 1);
        v("abort_drop_wd",   1, 1, 0, 0, 1,   1, 0, 1, 0, 0, 2);
        v("abort_release",   1, 1, 0, 0, 0,   0, 1, 0, 0, 1, 2);
        v("idle_ignore_wd",  1, 0, 1, 0, 1,   0, 1, 0, 0, 0, 0);
        v("idle_after_wd",   1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);

        // Back-to-back: request held through RELEASE with a CPU access pending.
        v("b2b_req",         1, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0);
        v("b2b_w0",          1, 0, 0, 1, 1,   1, 0, 0, 0, 0, 0);
        v("b2b_w1",          1, 0, 0, 1, 1,   1, 0, 0, 0, 0, 1);
        v("b2b_w2",          1, 0, 0, 1, 1,   1, 0, 0, 0, 0, 2);
        v("b2b_w3",          1, 0, 0, 1, 1,   1, 0, 0, 0, 0, 3);
        v("b2b_release",     1, 1, 0, 1, 0,   0, 1, 0, 1, 0, 4);
        v("b2b_idle",        1, 1, 0, 1, 0,   0, 1, 0, 0, 0, 0);
        v("b2b_drain",       1, 1, 0, 1, 0,   0, 1, 0, 0, 0, 0);
        v("b2b_drain_done",  1, 1, 1, 1, 0,   0, 1, 0, 0, 0, 0);
        v("b2b_grant2",      1, 0, 0, 1, 0,   1, 0, 0, 0, 0, 0);

        // Reset mid-grant with two words counted.
        v("rst_w0",          1, 0, 0, 1, 1,   1, 0, 0, 0, 0, 0);
        v("rst_w1",          1, 0, 0, 1, 1,   1, 0, 0, 0, 0, 1);
        v("rst_assert",      0, 0, 0, 1, 1,   1, 0, 0, 0, 0, 2);
        v("rst_after",       1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);

        // Request withdrawn during DRAIN beats a same-cycle CPU completion.
        v("drop_drain_in",   1, 1, 0, 1, 0,   0, 1, 0, 0, 0, 0);
        v("drop_drain",      1, 1, 1, 0, 0,   0, 1, 0, 0, 0, 0);
        v("drop_drain_idle", 1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);

        // Last word and request drop together counts as an abort.
        v("last_req",        1, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0);
        v("last_w0",         1, 0, 0, 1, 1,   1, 0, 0, 0, 0, 0);
        v("last_w1",         1, 0, 0, 1, 1,   1, 0, 0, 0, 0, 1);
        v("last_w2",         1, 0, 0, 1, 1,   1, 0, 0, 0, 0, 2);
        v("last_drop",       1, 0, 0, 0, 1,   1, 0, 0, 0, 0, 3);
        v("last_release",    1, 0, 0, 0, 0,   0, 1, 0, 0, 1, 3);
        v("last_idle",       1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);

        // Let the monitor drain the scoreboard, bounded in cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Arbitrates the single memory bus between the CPU pipeline's MEM stage and the DMA engine.
- On a DMA bus request it lets any in-flight CPU access finish, then grants the bus for at most BURST_LEN words, then hands the bus back.
- While the DMA owns the bus, a CPU memory access stalls the pipeline; the stall output drives the pipeline-register write enables low.

Parameters:
- BURST_LEN, 4: maximum words per DMA tenure (>=1).
- CNT_W, 3: width of word_cnt; must satisfy 2^CNT_W > BURST_LEN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- cpu_mem_req  input  1  MEM stage wants the bus (MEM_readM | MEM_writeM of a real instruction).
- cpu_mem_done  input  1  memory acknowledges completion of the CPU access this cycle.
- dma_br  input  1  DMA bus request; level-held for the whole tenure.
- dma_word_done  input  1  one DMA word transferred this cycle.
- bg  output  1  bus grant to the DMA.
- cpu_bus_en  output  1  CPU may drive the memory bus.
- stall_pipe  output  1  freeze IF/ID, ID/EX, EX/MEM and MEM/WB.
- dma_cmpl  output  1  one-cycle pulse: tenure ended after the full BURST_LEN words.
- dma_abort  output  1  one-cycle pulse: tenure ended early because dma_br dropped.
- word_cnt  output  CNT_W  words transferred in the current tenure.

Behaviour:
- States: IDLE, DRAIN, GRANT, RELEASE.
- Reset (reset_n=0 at a clock edge), from any state including mid-GRANT:
  - state becomes IDLE and word_cnt becomes 0.
  - Outputs after that edge: bg=0, cpu_bus_en=1, stall_pipe=0, dma_cmpl=0, dma_abort=0.
- Output decode:
  - bg=1 only in GRANT.
  - cpu_bus_en=1 in IDLE, DRAIN and RELEASE.
  - stall_pipe = (state==GRANT) & cpu_mem_req. This is a combinational path from the input; it is never asserted in other states.
- IDLE:
  - dma_br=0: stay in IDLE.
  - dma_br=1 and (cpu_mem_req=1 and cpu_mem_done=0): go to DRAIN. A pending CPU access always beats the DMA, including when both arrive in the same cycle.
  - dma_br=1 otherwise: go to GRANT; bg rises one cycle after dma_br is seen.
- DRAIN:
  - cpu_mem_done=1 and dma_br=1: go to GRANT.
  - dma_br=0 (checked first): go to IDLE with no grant.
  - Otherwise stay in DRAIN; there is no timeout.
- GRANT:
  - word_cnt increments on each cycle with dma_word_done=1.
  - dma_word_done=1 and word_cnt==BURST_LEN-1: go to RELEASE and set the completion flag.
  - dma_br=0 (checked before word counting): go to RELEASE and set the abort flag; a dma_word_done in that same cycle is ignored.
  - Simultaneous last word and dma_br drop: treated as abort.
- RELEASE (exactly one cycle):
  - bg=0; dma_cmpl or dma_abort asserted according to the flag.
  - word_cnt cleared to 0 at the exit edge.
  - Next state is IDLE unconditionally. The CPU therefore owns the bus for at least one cycle between tenures, even if dma_br stays high.
- dma_word_done outside GRANT is ignored; word_cnt never wraps.
- cpu_mem_done outside DRAIN has no effect on state.
- Latency: stall_pipe deasserts in the RELEASE cycle, so a stalled CPU access resumes one cycle after the last DMA word.

Test Plan:
- Reset mid-GRANT with word_cnt=2: reset_n=0 for one edge -> next cycle IDLE, bg=0, word_cnt=0, cpu_bus_en=1, no cmpl/abort pulse.
- Clean burst with BURST_LEN=4, CPU idle: dma_br=1 at cycle 0 -> bg=1 at cycle 1. Then 4 dma_word_done pulses -> word_cnt 1,2,3, RELEASE with dma_cmpl=1 for exactly one cycle, then IDLE.
- CPU in flight: cpu_mem_req=1 and dma_br=1 together, cpu_mem_done at cycle 3 -> DRAIN for cycles 1..3, bg=1 at cycle 4, no stall during DRAIN.
- CPU request during grant: cpu_mem_req=1 while in GRANT -> stall_pipe=1 for every GRANT cycle, 0 in the RELEASE cycle.
- Abort: dma_br drops after 2 words with dma_word_done=1 in the same cycle -> RELEASE with dma_abort=1, dma_cmpl=0, word_cnt stays 2 then clears.
- Back-to-back: dma_br held high through RELEASE with cpu_mem_req=1, cpu_mem_done=0 -> IDLE then DRAIN. The second grant occurs only after cpu_mem_done.
